// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit holding architectural HI/LO.
// Define MDU_SIGNED_EN to enable signed MULT/DIV via op[0]; otherwise every op is unsigned.
module mult_div_unit (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rdat1,
    input  logic [31:0] rdat2,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic [31:0] wdat,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t      state_reg, state_next;
    logic        issue, run_step, fix_step, mt_allowed;
    logic [4:0]  count_reg;
    logic        is_div_reg, div0_reg, done_reg;
    logic [31:0] a_raw_reg, b_reg, acc_hi_reg, acc_lo_reg, hi_reg, lo_reg;
    logic [31:0] a_mag, b_mag, res_hi, res_lo;
    logic [32:0] add_sum, rem_sh;
    logic [33:0] trial;
    logic [1:0]  unused_bits;

`ifdef MDU_SIGNED_EN
    logic a_neg, b_neg, neg_q_reg, neg_r_reg;

    assign a_neg = op[0] & rdat1[31];
    assign b_neg = op[0] & rdat2[31];
    assign a_mag = a_neg ? (~rdat1 + 32'd1) : rdat1;
    assign b_mag = b_neg ? (~rdat2 + 32'd1) : rdat2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (issue) begin
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
        end
    end
`else
    assign a_mag = rdat1;
    assign b_mag = rdat2;
`endif

    // trial[32] is provably zero whenever the subtraction result is kept.
    assign unused_bits = {op[0], trial[32]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count_reg == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue      = 1'b0;
        run_step   = 1'b0;
        fix_step   = 1'b0;
        mt_allowed = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                issue      = start;
                mt_allowed = 1'b1;
            end
            RUN: begin
                run_step = 1'b1;
                busy     = 1'b1;
            end
            FIX: begin
                fix_step = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Multiply: acc_lo holds the multiplier and fills with product bits from the top.
    // Divide: {acc_hi, acc_lo} is {remainder, dividend/quotient}.
    assign add_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, b_reg} : 33'd0);
    assign rem_sh  = {acc_hi_reg, acc_lo_reg[31]};
    assign trial   = {1'b0, rem_sh} - {2'b00, b_reg};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg  <= '0;
            is_div_reg <= 1'b0;
            div0_reg   <= 1'b0;
            done_reg   <= 1'b0;
            a_raw_reg  <= '0;
            b_reg      <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
        end else begin
            done_reg <= fix_step;
            if (issue) begin
                count_reg  <= '0;
                is_div_reg <= op[1];
                div0_reg   <= (rdat2 == 32'd0);
                a_raw_reg  <= rdat1;
                b_reg      <= op[1] ? b_mag : a_mag;
                acc_hi_reg <= '0;
                acc_lo_reg <= op[1] ? a_mag : b_mag;
            end else if (run_step) begin
                count_reg <= count_reg + 5'd1;
                if (!is_div_reg) begin
                    acc_hi_reg <= add_sum[32:1];
                    acc_lo_reg <= {add_sum[0], acc_lo_reg[31:1]};
                end else if (!trial[33]) begin
                    acc_hi_reg <= trial[31:0];
                    acc_lo_reg <= {acc_lo_reg[30:0], 1'b1};
                end else begin
                    acc_hi_reg <= rem_sh[31:0];
                    acc_lo_reg <= {acc_lo_reg[30:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        res_hi = acc_hi_reg;
        res_lo = acc_lo_reg;
        if (is_div_reg && div0_reg) begin
            res_hi = a_raw_reg;
            res_lo = 32'hFFFF_FFFF;
        end
`ifdef MDU_SIGNED_EN
        else if (is_div_reg) begin
            if (neg_q_reg) res_lo = -acc_lo_reg;
            if (neg_r_reg) res_hi = -acc_hi_reg;
        end else if (neg_q_reg) begin
            {res_hi, res_lo} = -{acc_hi_reg, acc_lo_reg};
        end
`endif
    end

    // A move-to write in the same cycle as start lands at issue; completion overwrites it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (fix_step) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
        end else if (mt_allowed) begin
            if (hi_wen) hi_reg <= wdat;
            if (lo_wen) lo_reg <= wdat;
        end
    end

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
